// File: rtl/irq_pkg.sv
// Shared constants for the interrupt scheduler: cause codes, irq_i bit
// indices, mstatus enable bits, privilege encodings and the FSM state enum.
package irq_pkg;

  localparam int NUM_IRQ = 6;

  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // irq_i bit order is {MEIP, SEIP, MTIP, STIP, MSIP, SSIP}
  localparam int B_SSIP = 0;
  localparam int B_MSIP = 1;
  localparam int B_STIP = 2;
  localparam int B_MTIP = 3;
  localparam int B_SEIP = 4;
  localparam int B_MEIP = 5;

  localparam int MSTATUS_SIE = 1;
  localparam int MSTATUS_MIE = 3;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_ISSUE,
    ST_FLUSH,
    ST_BACKOFF
  } state_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [63:0] pc;
    logic [63:0] tval;
    logic [63:0] wdata;
  } sysop_t;

  // The bit ordering makes the cause code of irq_i[idx] simply 2*idx+1.
  function automatic logic [3:0] irq_cause(input int unsigned idx);
    return 4'(2 * idx + 1);
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Takeable-interrupt filter and fixed-priority encoder.
// Purely combinational; o_cause is 0 when o_valid is low.
module irq_prio
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [63:0]        i_mie,
  input  logic [63:0]        i_mideleg,
  input  logic [63:0]        i_mstatus,
  input  logic [1:0]         i_priv,
  output logic               o_valid,
  output logic [3:0]         o_cause
);

  logic [NUM_IRQ-1:0] w_take;
  logic               w_m_en;
  logic               w_s_en;
  logic               w_unused;

  // Delegated interrupts are never enabled at M, since priv==M fails both terms.
  assign w_m_en = (i_priv != PRIV_M) | i_mstatus[MSTATUS_MIE];
  assign w_s_en = (i_priv == PRIV_U) | ((i_priv == PRIV_S) & i_mstatus[MSTATUS_SIE]);

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_take
    localparam int C = 2 * g + 1;
    assign w_take[g] = i_irq[g] & i_mie[C] & (i_mideleg[C] ? w_s_en : w_m_en);
  end

  always_comb begin
    o_valid = |w_take;
    o_cause = '0;
    if      (w_take[B_MEIP]) o_cause = irq_cause(B_MEIP);
    else if (w_take[B_MSIP]) o_cause = irq_cause(B_MSIP);
    else if (w_take[B_MTIP]) o_cause = irq_cause(B_MTIP);
    else if (w_take[B_SEIP]) o_cause = irq_cause(B_SEIP);
    else if (w_take[B_SSIP]) o_cause = irq_cause(B_SSIP);
    else if (w_take[B_STIP]) o_cause = irq_cause(B_STIP);
  end

  assign w_unused = ^{i_mie, i_mideleg, i_mstatus};

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: stalls the pipeline, waits for quiet, injects one trap op.
// Optional IRQ_SYNC_EN adds a two-flop synchronizer on every irq_i bit.
module irq_sched
  import irq_pkg::*;
#(
  parameter int HOLD_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [63:0]        mie_i,
  input  logic [63:0]        mideleg_i,
  input  logic [63:0]        mstatus_i,
  input  logic [1:0]         priv_i,
  input  logic [4:0]         pipe_op_i,
  input  logic [63:0]        pipe_pc_i,
  input  logic [63:0]        pipe_tval_i,
  input  logic [63:0]        pipe_wdata_i,
  input  logic               pipe_quiet_i,
  input  logic [63:0]        resume_pc_i,
  input  logic               trap_en_i,
  output logic               stall_o,
  output logic [4:0]         csr_op_o,
  output logic [63:0]        csr_pc_o,
  output logic [63:0]        csr_tval_o,
  output logic [63:0]        csr_wdata_o,
  output logic               csr_irq_o
);

  localparam int CNT_W = (HOLD_TIMEOUT > 2) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_TIMEOUT - 1);

  logic [NUM_IRQ-1:0] w_irq;
  logic               w_valid;
  logic [3:0]         w_cause;
  logic               w_exc;
  sysop_t             w_pipe;
  sysop_t             w_csr;

  state_e             r_state;
  logic               r_stall;
  logic               r_irq;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_cause;
  logic [63:0]        r_pc;

`ifdef IRQ_SYNC_EN
  logic [1:0][NUM_IRQ-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[0], irq_i};
  end
  assign w_irq = r_sync[1];
`else
  assign w_irq = irq_i;
`endif

  irq_prio u_prio (
    .i_irq     (w_irq),
    .i_mie     (mie_i),
    .i_mideleg (mideleg_i),
    .i_mstatus (mstatus_i),
    .i_priv    (priv_i),
    .o_valid   (w_valid),
    .o_cause   (w_cause)
  );

  assign w_exc  = pipe_op_i[4];
  assign w_pipe = '{op: pipe_op_i, pc: pipe_pc_i, tval: pipe_tval_i, wdata: pipe_wdata_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_stall <= 1'b0;
      r_irq   <= 1'b0;
      r_cnt   <= '0;
      r_cause <= '0;
      r_pc    <= '0;
    end else begin
      case (r_state)
        // A pipeline exception owns the cycle; the interrupt is re-evaluated after it.
        ST_IDLE: if (!w_exc && w_valid) begin
          r_state <= ST_HOLD;
          r_stall <= 1'b1;
          r_cnt   <= '0;
        end
        ST_HOLD: begin
          if (w_exc || !w_valid) begin
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
            r_cnt   <= '0;
          end else if (pipe_quiet_i) begin
            // Cause is chosen here, so a late higher-priority interrupt still wins.
            r_state <= ST_ISSUE;
            r_cause <= w_cause;
            r_pc    <= resume_pc_i;
            r_irq   <= 1'b1;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_BACKOFF;
            r_stall <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_FLUSH;
          r_irq   <= 1'b0;
        end
        ST_FLUSH: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
        ST_BACKOFF: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
          r_irq   <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_csr = w_pipe;
    case (r_state)
      ST_ISSUE: w_csr = '{op: {1'b1, r_cause}, pc: r_pc, tval: '0, wdata: '0};
      ST_FLUSH: w_csr.op = '0;
      default: ;
    endcase
  end

  assign stall_o     = r_stall;
  assign csr_irq_o   = r_irq;
  assign csr_op_o    = w_csr.op;
  assign csr_pc_o    = w_csr.pc;
  assign csr_tval_o  = w_csr.tval;
  assign csr_wdata_o = w_csr.wdata;

`ifndef SYNTHESIS
  // The CSR unit must take the redirect in the same cycle the trap op is offered.
  irq_sched_err: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ST_ISSUE) |-> trap_en_i);
`endif

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched (default build, IRQ_SYNC_EN undefined).
module tb_irq_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  irq;
  logic [63:0] mie, mideleg, mstatus;
  logic [1:0]  priv;
  logic [4:0]  pipe_op;
  logic [63:0] pipe_pc, pipe_tval, pipe_wdata;
  logic        quiet;
  logic [63:0] resume_pc;
  logic        trap_en;
  logic        stall;
  logic [4:0]  csr_op;
  logic [63:0] csr_pc, csr_tval, csr_wdata;
  logic        csr_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic acc;

  always #5 clk = ~clk;

  // Minimal CSR-unit model: takes every interrupt trap op it is offered.
  assign trap_en = csr_op[4] & csr_irq;

  irq_sched #(.HOLD_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq),
    .mie_i        (mie),
    .mideleg_i    (mideleg),
    .mstatus_i    (mstatus),
    .priv_i       (priv),
    .pipe_op_i    (pipe_op),
    .pipe_pc_i    (pipe_pc),
    .pipe_tval_i  (pipe_tval),
    .pipe_wdata_i (pipe_wdata),
    .pipe_quiet_i (quiet),
    .resume_pc_i  (resume_pc),
    .trap_en_i    (trap_en),
    .stall_o      (stall),
    .csr_op_o     (csr_op),
    .csr_pc_o     (csr_pc),
    .csr_tval_o   (csr_tval),
    .csr_wdata_o  (csr_wdata),
    .csr_irq_o    (csr_irq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; irq = '0; mie = '0; mideleg = '0; mstatus = '0; priv = 2'd0;
    pipe_op = 5'h03; pipe_pc = 64'h1000; pipe_tval = 64'h55; pipe_wdata = 64'hAA;
    quiet = 1'b1; resume_pc = 64'h8000_1000;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_irq", csr_irq, 0);
    chk("rst_op", csr_op, 5'h03);
    chk("rst_pc", csr_pc, 64'h1000);
    chk("rst_tval", csr_tval, 64'h55);
    chk("rst_wdata", csr_wdata, 64'hAA);

    // MTI at priv U, pipeline already quiet
    mie = 64'h80; irq = 6'b001000; #1;
    chk("t1_pre_stall", stall, 0);
    step; chk("t1_hold_stall", stall, 1); chk("t1_hold_op", csr_op, 5'h03);
    step;
    chk("t1_issue_op", csr_op, 5'h17);
    chk("t1_issue_irq", csr_irq, 1);
    chk("t1_issue_pc", csr_pc, 64'h8000_1000);
    chk("t1_issue_tval", csr_tval, 0);
    chk("t1_issue_stall", stall, 1);
    irq = '0;
    step; chk("t1_flush_op", csr_op, 0); chk("t1_flush_stall", stall, 1); chk("t1_flush_irq", csr_irq, 0);
    step; chk("t1_idle_stall", stall, 0); chk("t1_idle_op", csr_op, 5'h03);

    // MEI beats delegated STI at priv S with SIE
    priv = 2'd1; mstatus = 64'h2; mideleg = 64'h20; mie = 64'h820; irq = 6'b100100;
    step; chk("t2_hold_stall", stall, 1);
    step; chk("t2_mei_op", csr_op, 5'h1B);
    irq = '0; step(2);
    // delegated STI alone is takeable at S with SIE
    irq = 6'b000100;
    step(2); chk("t2_sti_op", csr_op, 5'h15);
    irq = '0; step(2);

    // MSI beats MTI and SEI
    priv = 2'd0; mideleg = '0; mie = 64'h288; irq = 6'b011010;
    step(2); chk("t2_msi_op", csr_op, 5'h13);
    irq = '0; step(2);

    // higher-priority arrival during HOLD wins
    quiet = 1'b0; mie = 64'h880; irq = 6'b001000;
    step; chk("t2_up_hold", stall, 1);
    irq = 6'b101000; quiet = 1'b1;
    step; chk("t2_up_op", csr_op, 5'h1B);
    irq = '0; step(2);

    // priv M with MIE clear: never taken
    priv = 2'd3; mstatus = '0; mie = 64'h80; irq = 6'b001000; acc = 1'b0;
    for (int i = 0; i < 100; i++) begin step; acc |= stall; end
    chk("t3_m_noie", acc, 0);
    // delegated at priv M: never taken, even with MIE set
    mstatus = 64'h8; mideleg = 64'h80; acc = 1'b0;
    for (int i = 0; i < 10; i++) begin step; acc |= stall; end
    chk("t3_m_deleg", acc, 0);
    irq = '0; mstatus = '0; mideleg = '0;
    step;

    // pipeline never quiet: 16 HOLD, 16 BACKOFF, one IDLE, then HOLD again
    priv = 2'd0; quiet = 1'b0; irq = 6'b001000;
    step; chk("t4_hold_start", stall, 1);
    acc = 1'b1;
    for (int i = 0; i < 15; i++) begin step; acc &= stall; end
    chk("t4_hold_16", acc, 1);
    step; chk("t4_backoff_stall", stall, 0); chk("t4_backoff_op", csr_op, 5'h03);
    acc = 1'b0;
    for (int i = 0; i < 15; i++) begin step; acc |= stall; end
    chk("t4_backoff_16", acc, 0);
    step; chk("t4_idle_stall", stall, 0);
    step; chk("t4_rehold", stall, 1);
    quiet = 1'b1;
    step; chk("t4_issue_op", csr_op, 5'h17);
    irq = '0; step(2);

    // pipeline exception during HOLD passes through and aborts the hold
    quiet = 1'b0; irq = 6'b001000;
    step; chk("t5_hold", stall, 1);
    pipe_op = 5'h12; #1;
    chk("t5_exc_op", csr_op, 5'h12); chk("t5_exc_irq", csr_irq, 0);
    step; chk("t5_idle_stall", stall, 0); chk("t5_idle_op", csr_op, 5'h12);
    pipe_op = 5'h03;
    step; chk("t5_rehold", stall, 1);
    quiet = 1'b1;
    step; chk("t5_issue_op", csr_op, 5'h17);
    irq = '0; step(2);

    // reset during ISSUE, interrupt gone afterwards
    quiet = 1'b0; irq = 6'b001000;
    step; quiet = 1'b1;
    step; chk("t6_issue_op", csr_op, 5'h17);
    #1 rst_n = 1'b0; #1;
    chk("t6_rst_stall", stall, 0); chk("t6_rst_irq", csr_irq, 0);
    chk("t6_rst_op", csr_op, 5'h03); chk("t6_rst_pc", csr_pc, 64'h1000);
    irq = '0; #2 rst_n = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin step; acc |= stall | csr_irq; end
    chk("t6_no_reissue", acc, 0);

    // reset during ISSUE, interrupt still pending: it is taken again
    quiet = 1'b0; irq = 6'b001000;
    step; quiet = 1'b1;
    step; chk("t6b_issue_op", csr_op, 5'h17);
    #1 rst_n = 1'b0; #1;
    chk("t6b_rst_op", csr_op, 5'h03);
    #2 rst_n = 1'b1;
    step; chk("t6b_hold", stall, 1);
    step; chk("t6b_reissue_op", csr_op, 5'h17);
    irq = '0; step(2);
    chk("t6b_idle", stall, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_sched.md
# irq_sched

Interrupt scheduler sitting between the pipeline's system-op port and the CSR/trap unit. It watches the six standard machine/supervisor interrupt lines. It decides whether any pending interrupt is takeable under the current privilege, enable and delegation state, and quiesces the pipeline through a stall handshake. It then injects exactly one trap-entry op into the CSR unit. Otherwise it passes pipeline system ops through unchanged.

## Interface
- `HOLD_TIMEOUT`, 16: max cycles spent waiting for `pipe_quiet_i` before abandoning an injection.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq_i` in 6: interrupt lines, bit order {MEIP, SEIP, MTIP, STIP, MSIP, SSIP} (bits 5..0).
- `mie_i`, `mideleg_i`, `mstatus_i` in 64 each: current CSR values.
- `priv_i` in 2: current privilege (U=0, S=1, M=3).
- `pipe_op_i` in 5: pipeline system op; bit 4 = exception, [3:0] = cause.
- `pipe_pc_i`, `pipe_tval_i`, `pipe_wdata_i` in 64 each: pipeline op operands.
- `pipe_quiet_i` in 1: pipeline has no instruction in flight past decode.
- `resume_pc_i` in 64: PC of the oldest unretired instruction, valid while `pipe_quiet_i`.
- `trap_en_i` in 1: CSR unit redirect strobe.
- `stall_o` out 1: request the pipeline to stop issuing.
- `csr_op_o` out 5, `csr_pc_o` / `csr_tval_o` / `csr_wdata_o` out 64: op port to the CSR unit.
- `csr_irq_o` out 1: the current `csr_op_o` exception is an interrupt; the CSR unit sets cause bit 63.

## Operation
- Pending vector: p = irq_i (synchronized per Configuration) AND corresponding mie bits (11,9,7,5,3,1).
- M-level interrupt (mideleg bit clear) is takeable iff priv<M, or priv==M and mstatus.MIE.
- Delegated interrupt is takeable iff priv<S, or priv==S and mstatus.SIE. It is never taken at priv==M.
- Fixed priority among takeable interrupts: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5).
- FSM states:
  - IDLE: pass-through; csr_* = pipe_*, csr_irq_o=0. A takeable interrupt goes to HOLD next cycle with stall_o=1.
  - HOLD: stall_o=1; csr_op_o = pipe_op_i pass-through so in-flight ops drain. If pipe_quiet_i and an interrupt is still takeable, latch its cause and resume_pc_i, then go to ISSUE. If none is takeable, go to IDLE. If the timeout counter reaches HOLD_TIMEOUT-1, go to BACKOFF.
  - ISSUE (1 cycle): csr_op_o = {1'b1, cause}, csr_pc_o = latched pc, csr_tval_o = 0, csr_irq_o=1, stall_o=1. Pipeline op is masked to 0. Go to FLUSH.
  - FLUSH (1 cycle): stall_o=1, csr_op_o=0. Go to IDLE; the pipeline follows the trap_en redirect.
  - BACKOFF: stall_o=0, pass-through for HOLD_TIMEOUT cycles, then IDLE. This guarantees forward progress.
- A pipeline exception (pipe_op_i[4]) in IDLE or HOLD always passes through with priority. If seen in HOLD, return to IDLE; the interrupt is re-evaluated after the trap.
- Cause selection is re-evaluated at the HOLD->ISSUE edge, not at HOLD entry. A higher-priority interrupt arriving mid-HOLD wins.

## Timing
- Reset: state IDLE, stall_o=0, csr_irq_o=0, counters 0, latched pc/cause 0. Pass-through outputs follow pipe_* immediately after reset.
- Interrupt at cycle N (post-sync) gives stall_o=1 at N+1. pipe_quiet_i first seen at cycle Q gives ISSUE at Q+1 and FLUSH at Q+2. The earliest injection is N+2.
- Timeout counter runs only in HOLD and BACKOFF; it clears on every state change.
- trap_en_i is expected in the ISSUE cycle. If it is absent there, assert `irq_sched_err` under simulation only (non-synthesizable assertion).
- Reset mid-HOLD/ISSUE: immediate return to IDLE. No partial op is emitted.

## Configuration
- `IRQ_SYNC_EN` defined: each irq_i bit passes a two-flop synchronizer (reset 0), adding 2 cycles of latency.
- `IRQ_SYNC_EN` undefined: irq_i is used directly (synchronous sources only).

## Structure
- Shared package `irq_pkg`: cause constants (IRQ_SSI=1 … IRQ_MEI=11), irq_i bit indices, mstatus bit positions reused from the CSR defines, and the FSM state enum.
- One sub-module, `irq_prio`: combinational takeable-filter plus priority encoder. It outputs valid and the 4-bit cause.

## Test plan
- MTIP=1, mie[7]=1, priv=U, pipe_quiet_i tied 1 -> stall_o at N+1, ISSUE at N+2 with csr_op_o=5'h17, csr_irq_o=1, csr_pc_o=resume_pc_i.
- MEIP and STIP both pending, priv=S, SIE=1, mideleg[5]=1 -> cause 11 injected.
- priv=M, MIE=0, MTIP pending -> stall_o stays 0 for 100 cycles.
- pipe_quiet_i held 0 -> BACKOFF after 16 HOLD cycles, stall_o=0 for 16 cycles, then HOLD again.
- Pipeline exception 5'h12 during HOLD -> passed through unchanged, FSM returns to IDLE, interrupt injected afterward.
- rst_n low during ISSUE -> all outputs at reset values, no second injection after release unless the interrupt is still takeable.
